// File: rtl/seq_comp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM state and {lt,eq,gt} result encoding.
package seq_comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [2:0] res_t;  // {lt, eq, gt}

  localparam res_t RES_NONE = 3'b000;
  localparam res_t RES_LT   = 3'b100;
  localparam res_t RES_EQ   = 3'b010;
  localparam res_t RES_GT   = 3'b001;

  function automatic res_t slice_res(input logic lt, input logic gt);
    return lt ? RES_LT : (gt ? RES_GT : RES_EQ);
  endfunction

endpackage

// File: rtl/cmp2_slice.sv
// Combinational 2-bit unsigned magnitude comparator slice.
module cmp2_slice (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic       lt,
  output logic       eq,
  output logic       gt
);

  assign lt = (x < y);
  assign eq = (x == y);
  assign gt = (x > y);

endmodule

// File: rtl/seq_mag_comp_ctrl.sv
// Sequencer comparing two WIDTH-bit operands one 2-bit pair per cycle, MSB pair first.
// Build option: define SEQ_COMP_EARLY_EXIT_EN to stop on the first unequal pair.
module seq_mag_comp_ctrl
  import seq_comp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             alb,
  output logic             aeb,
  output logic             agb
);

  localparam int NPAIR = WIDTH / 2;
  localparam int IDXW  = (NPAIR > 1) ? $clog2(NPAIR) : 1;

  state_t           state, state_n;
  logic [WIDTH-1:0] aq, bq;
  logic [IDXW-1:0]  idx;
  res_t             res_q, res_n;
  logic             load_res;
  logic             s_lt, s_eq, s_gt;
  res_t             s_res;

`ifndef SEQ_COMP_EARLY_EXIT_EN
  logic             decided;
  res_t             dec_res;
`endif

  // Operands shift left each RUN cycle, so the slice always sees the current pair at the top.
  cmp2_slice u_slice (
    .x  (aq[WIDTH-1 -: 2]),
    .y  (bq[WIDTH-1 -: 2]),
    .lt (s_lt),
    .eq (s_eq),
    .gt (s_gt)
  );

  assign s_res = slice_res(s_lt, s_gt);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n  = state;
    res_n    = res_q;
    load_res = 1'b0;
    case (state)
      IDLE: if (start) state_n = RUN;
      RUN: begin
`ifdef SEQ_COMP_EARLY_EXIT_EN
        if (!s_eq || idx == '0) begin
          state_n  = DONE;
          res_n    = s_res;
          load_res = 1'b1;
        end
`else
        if (idx == '0) begin
          state_n  = DONE;
          res_n    = decided ? dec_res : s_res;
          load_res = 1'b1;
        end
`endif
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      res_q <= RES_NONE;
    end else begin
      state <= state_n;
      if (load_res) res_q <= res_n;
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded on start before being read.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      aq  <= a;
      bq  <= b;
      idx <= IDXW'(NPAIR - 1);
`ifndef SEQ_COMP_EARLY_EXIT_EN
      decided <= 1'b0;
`endif
    end else if (state == RUN) begin
      aq  <= aq << 2;
      bq  <= bq << 2;
      idx <= idx - 1'b1;
`ifndef SEQ_COMP_EARLY_EXIT_EN
      // The first unequal pair decides; later pairs are scanned but cannot override it.
      if (!decided && !s_eq) begin
        decided <= 1'b1;
        dec_res <= s_res;
      end
`endif
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign {alb, aeb, agb} = res_q;

endmodule

// File: tb/tb_seq_mag_comp_ctrl.sv
// Randomized self-checking bench for seq_mag_comp_ctrl against an arithmetic reference model.
module tb_seq_mag_comp_ctrl;

  localparam int W  = 8;
  localparam int NP = W / 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, alb, aeb, agb;

  int n_vec = 0;
  int n_err = 0;

  seq_mag_comp_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .alb   (alb),
    .aeb   (aeb),
    .agb   (agb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_flags(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x < y)       return 3'b100;
    else if (x == y) return 3'b010;
    else             return 3'b001;
  endfunction

  // Number of RUN cycles the compare should take.
  function automatic int exp_k(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SEQ_COMP_EARLY_EXIT_EN
    for (int p = NP - 1; p >= 0; p--)
      if (((int'(x) >> (2 * p)) & 3) != ((int'(y) >> (2 * p)) & 3)) return NP - p;
    return NP;
`else
    return NP;
`endif
  endfunction

  task automatic run_cmp(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    int edges, busy_n, k;
    k = exp_k(x, y);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    busy_n = 0;
    while (!done && edges < 20) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(edges), 32'(k + 1));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(k));
    check({tag, "_flags"}, 32'({alb, aeb, agb}), 32'(exp_flags(x, y)));
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n, pulses;
    logic [W-1:0] x, y;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("reset_outputs", 32'({busy, done, alb, aeb, agb}), 32'd0);
    end

    run_cmp(8'hA5, 8'hA5, "eq_a5");
    run_cmp(8'h80, 8'h7F, "gt_80_7f");
    run_cmp(8'h12, 8'h13, "lt_12_13");

    // Start during RUN with different operands must be ignored.
    @(negedge clk);
    a = 8'h34; b = 8'h56; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    a = 8'h00; b = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    check("held_flags_in_run", 32'({alb, aeb, agb}), 32'(3'b100));
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ignore_start_done", 32'(done), 32'd1);
    check("ignore_start_flags", 32'({alb, aeb, agb}), 32'(3'b100));
    n = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (busy || done) n++;
    end
    check("no_restart_after_ignored_start", 32'(n), 32'd0);
    check("flags_held_idle", 32'({alb, aeb, agb}), 32'(3'b100));

    // Reset in the middle of a compare aborts it.
    @(negedge clk);
    a = 8'h00; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
`ifndef SEQ_COMP_EARLY_EXIT_EN
    @(posedge clk); #1;
`endif
    check("busy_before_abort", 32'(busy), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("abort_outputs", 32'({busy, done, alb, aeb, agb}), 32'd0);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    check("abort_flags_cleared", 32'({alb, aeb, agb}), 32'd0);
    run_cmp(8'hFF, 8'h00, "gt_after_abort");

    for (int i = 0; i < 1000; i++) begin
      x = W'($urandom);
      case ($urandom_range(0, 3))
        0:       y = x;
        1:       y = x ^ W'(($urandom_range(1, 3)) << (2 * $urandom_range(0, NP - 1)));
        default: y = W'($urandom);
      endcase
      run_cmp(x, y, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
